btn_debouncer: RTL

- Conditions a raw, asynchronous, bouncing push-button input into clean signals in the system clock domain.
- Outputs: a debounced level, a one-cycle press pulse, a one-cycle release pulse, and optional hold-to-repeat pulses.
- Drives the button-event side of the counter blocks. o_btn_pulse is the intended source of the count/step event that the counter consumes.

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 21 ++
 rtl/btn_debouncer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: synchronize, debounce, and emit press/release/repeat strobes.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_DELAY      = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_btn_pulse,
  output logic o_btn_release
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic          btn_s;
  logic          level_c;
  logic          press_c;
  logic          release_c;
  logic          rpt_c;

  sync_2ff u_sync (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_btn),
    .q     (btn_s)
  );

  // State and debounce counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RELEASED;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = WAIT_PRESS;
          dcnt_nxt  = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_s)                state_nxt = RELEASED;
        else if (dcnt == DCNT_LAST) state_nxt = PRESSED;
        else                       dcnt_nxt  = dcnt + DW'(1);
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = WAIT_RELEASE;
          dcnt_nxt  = '0;
        end
      end
      WAIT_RELEASE: begin
        if (btn_s)                 state_nxt = PRESSED;
        else if (dcnt == DCNT_LAST) state_nxt = RELEASED;
        else                       dcnt_nxt  = dcnt + DW'(1);
      end
      default: begin
        state_nxt = RELEASED;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Output decode from the transition being taken, so the registered outputs line up with it.
  always_comb begin
    level_c   = 1'b0;
    press_c   = 1'b0;
    release_c = 1'b0;
    level_c   = (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);
    press_c   = (state == WAIT_PRESS) && (state_nxt == PRESSED);
    release_c = (state == WAIT_RELEASE) && (state_nxt == RELEASED);
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int unsigned RW = cnt_width(HOLD_DELAY);
      localparam logic [RW-1:0] RCNT_LAST   = RW'(HOLD_DELAY - 1);
      localparam logic [RW-1:0] RCNT_RELOAD = RW'(HOLD_DELAY - REPEAT_PERIOD);

      logic [RW-1:0] rcnt;

      // Repeats fire only while staying in PRESSED; leaving on the same cycle suppresses it.
      assign rpt_c = (state == PRESSED) && (state_nxt == PRESSED) && (rcnt == RCNT_LAST);

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          rcnt <= '0;
        end else if (press_c) begin
          rcnt <= '0;
        end else if (rpt_c) begin
          rcnt <= RCNT_RELOAD;
        end else if (((state == PRESSED) || (state == WAIT_RELEASE)) && (rcnt != RCNT_LAST)) begin
          rcnt <= rcnt + RW'(1);
        end
      end
    end else begin : g_no_repeat
      assign rpt_c = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_btn_level   <= 1'b0;
      o_btn_pulse   <= 1'b0;
      o_btn_release <= 1'b0;
    end else begin
      o_btn_level   <= level_c;
      o_btn_pulse   <= press_c | rpt_c;
      o_btn_release <= release_c;
    end
  end

endmodule
